// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - pixel-side and DAC-side signal bundle for vga_timing
//
// Purpose: groups the colour inputs, the counter/strobe outputs and the DAC
// outputs of vga_timing so they travel as one port.
// Ports (signals):
//   red_in/green_in/blue_in [7:0] - colour for the current pixel_x/pixel_y (renderer -> timing)
//   pixel_x/pixel_y        [9:0] - current horizontal/vertical counters
//   video_on, pixel_tick, frame_start - counter-side status strobes
//   vga_r/vga_g/vga_b      [7:0] - colour to the DAC, one pixel behind the counters
//   vga_hsync, vga_vsync          - active-low syncs
//   vga_blank_n, vga_sync_n       - active-low blank, sync-on-green tied off
//   vga_clk                       - pixel clock for the DAC
// Modports: master = timing generator, slave = renderer / DAC side.
interface vga_timing_if;
  logic [7:0] red_in;
  logic [7:0] green_in;
  logic [7:0] blue_in;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic       pixel_tick;
  logic       frame_start;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic       vga_hsync;
  logic       vga_vsync;
  logic       vga_blank_n;
  logic       vga_sync_n;
  logic       vga_clk;

  modport master (
    input  red_in, green_in, blue_in,
    output pixel_x, pixel_y, video_on, pixel_tick, frame_start,
    output vga_r, vga_g, vga_b, vga_hsync, vga_vsync,
    output vga_blank_n, vga_sync_n, vga_clk
  );

  modport slave (
    output red_in, green_in, blue_in,
    input  pixel_x, pixel_y, video_on, pixel_tick, frame_start,
    input  vga_r, vga_g, vga_b, vga_hsync, vga_vsync,
    input  vga_blank_n, vga_sync_n, vga_clk
  );
endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA pixel-clock divider, raster counters and DAC output stage
//
// Purpose: divides the system clock by CLK_DIV into a pixel strobe, walks the
// raster with h/v counters, and registers syncs, blank and colour for the DAC
// one pixel behind the counters.
// Ports:
//   clock - system clock
//   reset - asynchronous active-high reset
//   vga   - vga_timing_if.master bundle (colour in, counters/strobes/DAC out)
module vga_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic         clock,
  input  logic         reset,
  vga_timing_if.master vga
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_FIRST = H_VISIBLE + H_FRONT;
  localparam int HS_LAST  = H_VISIBLE + H_FRONT + H_SYNC - 1;
  localparam int VS_FIRST = V_VISIBLE + V_FRONT;
  localparam int VS_LAST  = V_VISIBLE + V_FRONT + V_SYNC - 1;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] r_div_cnt;
  logic [9:0]       r_h_cnt;
  logic [9:0]       r_v_cnt;
  logic             r_frame_start;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_blank_n;
  logic [7:0]       r_red;
  logic [7:0]       r_green;
  logic [7:0]       r_blue;

  logic w_pixel_tick;
  logic w_h_last;
  logic w_v_last;
  logic w_video_on;
  logic w_hsync_raw;
  logic w_vsync_raw;

  // The tick is decoded from the divider itself, so it is low in reset
  // (divider held at 0) and lasts exactly one system clock.
  assign w_pixel_tick = (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign w_h_last     = (r_h_cnt == 10'(H_TOTAL - 1));
  assign w_v_last     = (r_v_cnt == 10'(V_TOTAL - 1));
  assign w_video_on   = (r_h_cnt < 10'(H_VISIBLE)) && (r_v_cnt < 10'(V_VISIBLE));
  assign w_hsync_raw  = !((r_h_cnt >= 10'(HS_FIRST)) && (r_h_cnt <= 10'(HS_LAST)));
  assign w_vsync_raw  = !((r_v_cnt >= 10'(VS_FIRST)) && (r_v_cnt <= 10'(VS_LAST)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (w_pixel_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_pixel_tick) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  // Registered so the pulse coincides with the first clock showing (0,0);
  // reset release never produces one since no tick precedes it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_pixel_tick && w_h_last && w_v_last;
    end
  end

  // DAC stage captures the pixel being completed on this tick, which puts
  // it exactly one pixel behind the counters and holds it between ticks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hsync   <= 1'b1;
      r_vsync   <= 1'b1;
      r_blank_n <= 1'b0;
      r_red     <= 8'h00;
      r_green   <= 8'h00;
      r_blue    <= 8'h00;
    end else if (w_pixel_tick) begin
      r_hsync   <= w_hsync_raw;
      r_vsync   <= w_vsync_raw;
      r_blank_n <= w_video_on;
      r_red     <= w_video_on ? vga.red_in   : 8'h00;
      r_green   <= w_video_on ? vga.green_in : 8'h00;
      r_blue    <= w_video_on ? vga.blue_in  : 8'h00;
    end
  end

  assign vga.pixel_x     = r_h_cnt;
  assign vga.pixel_y     = r_v_cnt;
  assign vga.video_on    = w_video_on;
  assign vga.pixel_tick  = w_pixel_tick;
  assign vga.frame_start = r_frame_start;
  assign vga.vga_r       = r_red;
  assign vga.vga_g       = r_green;
  assign vga.vga_b       = r_blue;
  assign vga.vga_hsync   = r_hsync;
  assign vga.vga_vsync   = r_vsync;
  assign vga.vga_blank_n = r_blank_n;
  assign vga.vga_sync_n  = 1'b0;
  assign vga.vga_clk     = (r_div_cnt >= DIV_W'(CLK_DIV / 2));

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The module SHALL have parameter H_VISIBLE, default 640, meaning active pixels per line.
REQ-002 The module SHALL have parameters H_FRONT 16, H_SYNC 96 and H_BACK 48, meaning horizontal porch and sync widths in pixels.
REQ-003 The module SHALL have parameter V_VISIBLE, default 480, meaning active lines per frame.
REQ-004 The module SHALL have parameters V_FRONT 10, V_SYNC 2 and V_BACK 33, meaning vertical porch and sync widths in lines.
REQ-005 The module SHALL have parameter CLK_DIV, default 2, meaning system clocks per pixel; legal values are 2 or greater.
REQ-006 The module SHALL have one clock, and its reset SHALL be asynchronous and active-high.
REQ-007 The ports SHALL be as follows, one per line:
- clock  input  1  system clock (50 MHz)
- reset  input  1  asynchronous active-high reset
- red_in, green_in, blue_in  input  8 each  colour from the downstream renderer for the current pixel_x/pixel_y
- pixel_x  output  10  horizontal counter, range 0..799
- pixel_y  output  10  vertical counter, range 0..524
- video_on  output  1  current counters are inside the visible area
- pixel_tick  output  1  one-clock pixel strobe
- frame_start  output  1  one-clock pulse at the start of each frame
- vga_r, vga_g, vga_b  output  8 each  colour sent to the DAC
- vga_hsync, vga_vsync  output  1  sync signals, active-low
- vga_blank_n  output  1  active-low blank
- vga_sync_n  output  1  tied to 0
- vga_clk  output  1  pixel clock for the DAC

Function
REQ-008 The divider div_cnt SHALL count 0..CLK_DIV-1 and then wrap to 0.
REQ-009 pixel_tick SHALL be 1 exactly on the clocks where div_cnt == CLK_DIV-1.
REQ-010 vga_clk SHALL be 1 while div_cnt >= CLK_DIV/2 (integer division), and 0 otherwise.
REQ-011 H_TOTAL SHALL equal H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800), and V_TOTAL SHALL equal V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
REQ-012 On each pixel_tick, h_cnt SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and v_cnt SHALL increment.
REQ-013 v_cnt SHALL wrap from V_TOTAL-1 to 0 only on the tick where h_cnt also wraps.
REQ-014 The counters SHALL hold their values on all non-tick clocks.
REQ-015 pixel_x SHALL equal h_cnt and pixel_y SHALL equal v_cnt, both registered, with no offset.
REQ-016 video_on SHALL be combinational and equal (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
REQ-017 Raw hsync SHALL be 0 for h_cnt in [656, 751] and 1 otherwise.
REQ-018 Raw vsync SHALL be 0 for v_cnt in [490, 491] and 1 otherwise.
REQ-019 frame_start SHALL be 1 for the single clock on which the counters change from (799,524) to (0,0).
REQ-020 Output stage: the downstream renderer registers its colour one clock after the counters change.
REQ-021 On each pixel_tick, the module SHALL register vga_hsync, vga_vsync and vga_blank_n from the raw hsync, raw vsync and video_on of the pixel just completed.
REQ-022 On each pixel_tick, vga_r/g/b SHALL load red_in/green_in/blue_in when video_on is 1, and 8'h00 otherwise.
REQ-023 As a result, the DAC outputs SHALL lag the counters by exactly one pixel and remain stable between ticks.
REQ-024 Colour inputs SHALL be ignored on non-tick clocks.
REQ-025 All arithmetic SHALL be unsigned, 10-bit counters with no overflow beyond the wrap points.

Reset
REQ-026 While reset is 1, the module SHALL hold div_cnt, h_cnt, v_cnt, pixel_x and pixel_y at 0.
REQ-027 While reset is 1, pixel_tick, frame_start and vga_clk SHALL be 0.
REQ-028 While reset is 1, vga_r/g/b SHALL be 0 and vga_blank_n SHALL be 0.
REQ-029 While reset is 1, vga_hsync and vga_vsync SHALL be 1 (inactive).
REQ-030 Reset asserted mid-frame SHALL take effect immediately, without waiting for a clock edge.
REQ-031 After reset is released, the first pixel_tick SHALL occur CLK_DIV clocks later and advance the counters to (1,0).
REQ-032 No frame_start SHALL be produced on release of reset.

Verification
REQ-033 Scenario: release reset, then run 2x800x525 clocks -> exactly one frame_start per frame.
REQ-034 Scenario: the interval between successive frame_start pulses SHALL be 840000 clocks.
REQ-035 Scenario: observe h_cnt on one line -> vga_hsync falls one tick after h_cnt=656, rises one tick after h_cnt=752, and stays low for 96 ticks (192 clocks).
REQ-036 Scenario: observe v_cnt across frames -> vga_vsync is low for exactly 2 lines (1600 ticks), starting one tick after (0,490).
REQ-037 Scenario: drive red_in = 8'hFF constant -> vga_r = FF only when the registered video_on is 1; vga_r = 0 for pixels at h_cnt >= 640 or v_cnt >= 480.
REQ-038 Scenario: set red_in = pixel_x[7:0] -> vga_r equals the previous tick's pixel_x[7:0], confirming one-pixel latency.
REQ-039 Scenario: assert reset asynchronously at (320,240), mid-divider -> all outputs go to their reset values before the next clock; after release, counting resumes from (0,0).
